wb_data_ram: RTL



---
 rtl/wb_data_ram.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/wb_data_ram.sv
// wb_data_ram: Wishbone-style single-port 32-bit data RAM with programmable wait states.
// Define WB_RAM_ERR_EN to terminate out-of-range requests with err_o instead of ack_o.
module wb_data_ram #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned AW          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int unsigned DEPTH = 32'(1) << AW;
  localparam int unsigned CW    = 4;
  localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

`ifdef WB_RAM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic [31:0]   mem [DEPTH];

  logic [1:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          req_we, req_we_d;
  logic          req_oor, req_oor_d;
  logic [AW-1:0] req_idx, req_idx_d;
  logic [31:0]   req_dat, req_dat_d;
  logic          ack_d, err_d;
  logic [31:0]   dat_d;

  logic          in_oor;
  logic          cur_we, cur_oor;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_dat;
  logic          enter_ack;
  logic          mem_we;

  assign in_oor = (adr_i >> (AW + 2)) != 32'd0;

  // With zero wait states ACK is entered on the accept edge itself, so the
  // request being accepted is used directly instead of the latched copy.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_we  = we_i;
      cur_oor = in_oor;
      cur_idx = adr_i[AW+1:2];
      cur_dat = dat_i;
    end else begin
      cur_we  = req_we;
      cur_oor = req_oor;
      cur_idx = req_idx;
      cur_dat = req_dat;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    req_we_d  = req_we;
    req_oor_d = req_oor;
    req_idx_d = req_idx;
    req_dat_d = req_dat;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = 32'd0;
    enter_ack = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cyc_i) begin
          req_we_d  = we_i;
          req_oor_d = in_oor;
          req_idx_d = adr_i[AW+1:2];
          req_dat_d = dat_i;
          cnt_d     = WAIT_INIT;
          if (WAIT_INIT == '0) begin
            enter_ack = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            enter_ack = 1'b1;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_ack) begin
      state_d = ST_ACK;
      ack_d   = !(ERR_EN && cur_oor);
      err_d   = ERR_EN && cur_oor;
      if (!cur_we && !cur_oor) begin
        dat_d = mem[cur_idx];
      end
    end
  end

  // Reset gating keeps a pending write from landing while rst is held low
  assign mem_we = enter_ack && cur_we && !cur_oor && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req_we  <= 1'b0;
      req_oor <= 1'b0;
      req_idx <= '0;
      req_dat <= 32'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      dat_o   <= 32'd0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      req_we  <= req_we_d;
      req_oor <= req_oor_d;
      req_idx <= req_idx_d;
      req_dat <= req_dat_d;
      ack_o   <= ack_d;
      err_o   <= err_d;
      dat_o   <= dat_d;
    end
  end

  // Storage array is deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= cur_dat;
    end
  end

endmodule
